// File: rtl/program_counter_8085.sv
// 16-bit program counter for the 8085-compatible core: byte-wise loads from the
// internal data bus, post-fetch increment, and a tri-state drive onto the address bus.
module program_counter_8085 (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        en_read_i,
    input  logic        inc_i,
    input  logic        ld_high_i,
    input  logic [7:0]  data_bus_i,
    output logic [15:0] addr_bus_o
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    // Load beats increment; ld_high only matters while a load is requested.
    always_comb begin
        pc_d = pc_q;
        if (en_read_i) begin
            if (ld_high_i) begin
                pc_d[15:8] = data_bus_i;
            end else begin
                pc_d[7:0] = data_bus_i;
            end
        end else if (inc_i) begin
            pc_d = pc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= 16'h0000;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign addr_bus_o = en_i ? pc_q : 16'hzzzz;

endmodule

// File: tb/tb_program_counter_8085.sv
// Self-checking bench for program_counter_8085: expected bus values are queued when
// stimulus is driven and popped when the DUT output is sampled.
module tb_program_counter_8085;

    logic        clk;
    logic        reset;
    logic        en;
    logic        en_read;
    logic        inc;
    logic        ld_high;
    logic [7:0]  data_bus;
    logic [15:0] addr_bus;

    int checks;
    int failures;
    logic [15:0] exp_q[$];
    logic [15:0] exp;

    program_counter_8085 dut (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en),
        .en_read_i  (en_read),
        .inc_i      (inc),
        .ld_high_i  (ld_high),
        .data_bus_i (data_bus),
        .addr_bus_o (addr_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here, away from edges.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic rd, input logic hi, input logic in, input logic [7:0] d);
        en_read  = rd;
        ld_high  = hi;
        inc      = in;
        data_bus = d;
    endtask

    task automatic test_reset();
        set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
        en    = 1'b1;
        reset = 1'b1;
        #2;
        exp_q.push_back(16'h0000);
        exp = exp_q.pop_front();
        checks++;
        if (addr_bus !== exp) begin
            $display("FAIL reset_initial: got %h expected %h", addr_bus, exp);
            failures++;
        end
        cyc();
        reset = 1'b0;
        set_ctl(1'b1, 1'b0, 1'b0, 8'h5A);
        exp_q.push_back(16'h005A);
        cyc();
        exp = exp_q.pop_front();
        checks++;
        if (addr_bus !== exp) begin
            $display("FAIL reset_preload: got %h expected %h", addr_bus, exp);
            failures++;
        end
        // Assert reset mid-cycle while an increment is pending.
        set_ctl(1'b0, 1'b0, 1'b1, 8'h00);
        #2;
        reset = 1'b1;
        exp_q.push_back(16'h0000);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (addr_bus !== exp) begin
            $display("FAIL reset_async: got %h expected %h", addr_bus, exp);
            failures++;
        end
        en = 1'b0;
        exp_q.push_back(16'hzzzz);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (addr_bus !== exp) begin
            $display("FAIL reset_release: got %h expected %h", addr_bus, exp);
            failures++;
        end
        // Reset held across an edge overrides a load.
        en = 1'b1;
        set_ctl(1'b1, 1'b1, 1'b1, 8'hC3);
        exp_q.push_back(16'h0000);
        cyc();
        exp = exp_q.pop_front();
        checks++;
        if (addr_bus !== exp) begin
            $display("FAIL reset_wins: got %h expected %h", addr_bus, exp);
            failures++;
        end
        set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;
    endtask

    task automatic test_increment();
        en = 1'b1;
        set_ctl(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(16'(i));
        end
        for (int i = 1; i <= 3; i++) begin
            cyc();
            exp = exp_q.pop_front();
            checks++;
            if (addr_bus !== exp) begin
                $display("FAIL increment_%0d: got %h expected %h", i, addr_bus, exp);
                failures++;
            end
        end
        inc = 1'b0;
        exp_q.push_back(16'h0003);
        cyc();
        cyc();
        exp = exp_q.pop_front();
        checks++;
        if (addr_bus !== exp) begin
            $display("FAIL increment_hold: got %h expected %h", addr_bus, exp);
            failures++;
        end
    endtask

    task automatic test_byte_load();
        set_ctl(1'b1, 1'b0, 1'b0, 8'h34);
        exp_q.push_back(16'h0034);
        cyc();
        exp = exp_q.pop_front();
        checks++;
        if (addr_bus !== exp) begin
            $display("FAIL load_low: got %h expected %h", addr_bus, exp);
            failures++;
        end
        set_ctl(1'b1, 1'b1, 1'b0, 8'h12);
        exp_q.push_back(16'h1234);
        cyc();
        exp = exp_q.pop_front();
        checks++;
        if (addr_bus !== exp) begin
            $display("FAIL load_high: got %h expected %h", addr_bus, exp);
            failures++;
        end
        set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_carry_wrap();
        logic [7:0]  byte_v[6]  = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
        logic        hi_v[6]    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        rd_v[6]    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] want_v[6]  = '{16'h12FF, 16'h00FF, 16'h0100, 16'hFF00, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            set_ctl(rd_v[i], hi_v[i], !rd_v[i], byte_v[i]);
            exp_q.push_back(want_v[i]);
            cyc();
            exp = exp_q.pop_front();
            checks++;
            if (addr_bus !== exp) begin
                $display("FAIL carry_wrap_%0d: got %h expected %h", i, addr_bus, exp);
                failures++;
            end
        end
        set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_priority();
        set_ctl(1'b1, 1'b1, 1'b0, 8'h12);
        cyc();
        set_ctl(1'b1, 1'b0, 1'b0, 8'h34);
        cyc();
        set_ctl(1'b1, 1'b0, 1'b1, 8'hAA);
        exp_q.push_back(16'h12AA);
        cyc();
        exp = exp_q.pop_front();
        checks++;
        if (addr_bus !== exp) begin
            $display("FAIL priority_load_over_inc: got %h expected %h", addr_bus, exp);
            failures++;
        end
        // ld_high with no load must not change pc.
        set_ctl(1'b0, 1'b1, 1'b0, 8'h55);
        exp_q.push_back(16'h12AA);
        cyc();
        exp = exp_q.pop_front();
        checks++;
        if (addr_bus !== exp) begin
            $display("FAIL ld_high_ignored: got %h expected %h", addr_bus, exp);
            failures++;
        end
        set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_bus_release();
        logic        en_v[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] want_v[4] = '{16'h1234, 16'hzzzz, 16'h1234, 16'hzzzz};
        set_ctl(1'b1, 1'b0, 1'b0, 8'h34);
        cyc();
        set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            en = en_v[i];
            exp_q.push_back(want_v[i]);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (addr_bus !== exp) begin
                $display("FAIL bus_release_%0d: got %h expected %h", i, addr_bus, exp);
                failures++;
            end
        end
        // Released across an edge: pc keeps its value.
        cyc();
        en = 1'b1;
        exp_q.push_back(16'h1234);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (addr_bus !== exp) begin
            $display("FAIL bus_reenable: got %h expected %h", addr_bus, exp);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] model;
        model = 16'h1234;
        for (int i = 0; i < 20; i++) begin
            set_ctl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            if (en_read) begin
                if (ld_high) model[15:8] = data_bus;
                else         model[7:0]  = data_bus;
            end else if (inc) begin
                model = model + 16'd1;
            end
            exp_q.push_back(model);
            cyc();
            exp = exp_q.pop_front();
            checks++;
            if (addr_bus !== exp) begin
                $display("FAIL back_to_back_%0d: got %h expected %h", i, addr_bus, exp);
                failures++;
            end
        end
        set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        en       = 1'b0;
        reset    = 1'b1;
        set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_increment();
        test_byte_load();
        test_carry_wrap();
        test_priority();
        test_bus_release();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
